// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types for the Wishbone N-to-1 arbiter.
//   arb_state_t : arbiter FSM encoding (ARB_ABORT is only reachable when the
//                 WB_ARB_TIMEOUT_EN watchdog is compiled in).
// ---------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_ABORT   = 2'd2
    } arb_state_t;

endpackage : wb_pkg

// File: rtl/wb_rr_pick.sv
// ---------------------------------------------------------------------------
// wb_rr_pick
// Combinational round-robin picker. Searches the request vector starting one
// position above the last granted index, wrapping around, and returns the
// first requester found.
// Ports:
//   req    in  NUM_MASTERS  request vector (one bit per master)
//   last   in  IDX_W        index of the most recent grant
//   onehot out NUM_MASTERS  one-hot winner, all-zero when req is all-zero
//   idx    out IDX_W        index of the winner (0 when req is all-zero)
// ---------------------------------------------------------------------------
module wb_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic [NUM_MASTERS-1:0] onehot,
    output logic [IDX_W-1:0]       idx
);

    always_comb begin
        int   cand;
        logic found;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        // Offsets 1..NUM_MASTERS: the last winner is examined last, which is
        // what makes a release-and-rerequest lose to any other requester.
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(last) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
        onehot = found ? (NUM_MASTERS'(1) << idx) : '0;
    end

endmodule : wb_rr_pick

// File: rtl/wb_arbiter_n.sv
// ---------------------------------------------------------------------------
// wb_arbiter_n
// N-to-1 pipelined Wishbone B4 (with stall) arbiter. Masters are granted in
// round-robin order; a grant is held for the whole of the granted master's
// cyc. The granted master's bus is routed combinationally to the shared
// downstream port, and the slave's responses go back to that master only.
//
// Optional build macro WB_ARB_TIMEOUT_EN adds a watchdog: after
// TIMEOUT_CYCLES-1 consecutive unanswered cycles the master gets a one-cycle
// err, the downstream cycle is killed and the arbiter waits in ABORT until
// the master drops cyc.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wbm_cyc/stb/we [N]     upstream master strobes
//   wbm_adr/dat_m/sel [N]  upstream master address, write data, byte selects
//   wbm_dat_s [N]          read data broadcast to every master (qualify by ack)
//   wbm_ack/err/stall [N]  per-master responses
//   wbs_*                  shared downstream port toward the slave mux
//   grant_o                one-hot registered grant, all-zero when idle
// ---------------------------------------------------------------------------
module wb_arbiter_n
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_MASTERS-1:0]                    wbm_cyc,
    input  logic [NUM_MASTERS-1:0]                    wbm_stb,
    input  logic [NUM_MASTERS-1:0]                    wbm_we,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]    wbm_adr,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]    wbm_dat_m,
    input  logic [NUM_MASTERS-1:0][SELECT_WIDTH-1:0]  wbm_sel,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]    wbm_dat_s,
    output logic [NUM_MASTERS-1:0]                    wbm_ack,
    output logic [NUM_MASTERS-1:0]                    wbm_err,
    output logic [NUM_MASTERS-1:0]                    wbm_stall,
    output logic                                      wbs_cyc,
    output logic                                      wbs_stb,
    output logic                                      wbs_we,
    output logic [ADDR_WIDTH-1:0]                     wbs_adr,
    output logic [DATA_WIDTH-1:0]                     wbs_dat_m,
    output logic [SELECT_WIDTH-1:0]                   wbs_sel,
    input  logic [DATA_WIDTH-1:0]                     wbs_dat_s,
    input  logic                                      wbs_ack,
    input  logic                                      wbs_err,
    input  logic                                      wbs_stall,
    output logic [NUM_MASTERS-1:0]                    grant_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_t             state;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       last_grant;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   cyc_fwd;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req    (wbm_cyc),
        .last   (last_grant),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign cyc_fwd = (state == ARB_GRANTED) && wbm_cyc[grant_idx];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout_hit;

    assign timeout_hit = cyc_fwd && !wbs_ack && !wbs_err && (tmo_cnt == TMO_LAST);
`else
    // The watchdog limit only matters when the watchdog is compiled in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // Read data is broadcast; masters only look at it alongside their ack.
    assign wbm_dat_s = {NUM_MASTERS{wbs_dat_s}};

    always_comb begin
        wbs_cyc   = 1'b0;
        wbs_stb   = 1'b0;
        wbs_we    = 1'b0;
        wbs_adr   = '0;
        wbs_dat_m = '0;
        wbs_sel   = '0;
        wbm_ack   = '0;
        wbm_err   = '0;
        wbm_stall = '1;
        if (state == ARB_GRANTED) begin
            wbs_cyc              = cyc_fwd;
            wbs_stb              = cyc_fwd && wbm_stb[grant_idx];
            wbs_we               = wbm_we[grant_idx];
            wbs_adr              = wbm_adr[grant_idx];
            wbs_dat_m            = wbm_dat_m[grant_idx];
            wbs_sel              = wbm_sel[grant_idx];
            wbm_ack[grant_idx]   = wbs_ack;
            wbm_err[grant_idx]   = wbs_err;
            wbm_stall[grant_idx] = wbs_stall;
`ifdef WB_ARB_TIMEOUT_EN
            if (timeout_hit) begin
                wbs_cyc              = 1'b0;
                wbs_stb              = 1'b0;
                wbm_ack[grant_idx]   = 1'b0;
                wbm_err[grant_idx]   = 1'b1;
                wbm_stall[grant_idx] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
            grant_o    <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|wbm_cyc) begin
                        state      <= ARB_GRANTED;
                        grant_idx  <= pick_idx;
                        last_grant <= pick_idx;
                        grant_o    <= pick_onehot;
                    end
                end
                ARB_GRANTED: begin
                    if (!wbm_cyc[grant_idx]) begin
                        state   <= ARB_IDLE;
                        grant_o <= '0;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state <= ARB_ABORT;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ARB_ABORT: begin
                    if (!wbm_cyc[grant_idx]) begin
                        state   <= ARB_IDLE;
                        grant_o <= '0;
                    end
                end
`endif
                default: begin
                    state   <= ARB_IDLE;
                    grant_o <= '0;
                end
            endcase
`ifdef WB_ARB_TIMEOUT_EN
            if (state != ARB_GRANTED || wbs_ack || wbs_err || timeout_hit) begin
                tmo_cnt <= '0;
            end else if (cyc_fwd) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
        end
    end

endmodule : wb_arbiter_n

// File: tb/tb_wb_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_n
// Self-checking bench for wb_arbiter_n (4 masters, 32-bit). A behavioural
// model of the grant owner is compared against every DUT output on each
// falling edge; directed scenarios add literal expectations. The timeout
// scenario runs only when WB_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_n;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    localparam int S_AUTO  = 0;
    localparam int S_BURST = 1;
    localparam int S_NOACK = 2;
    localparam int S_ERR1  = 3;
    localparam int S_RAND  = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N-1:0]           wbm_cyc, wbm_stb, wbm_we;
    logic [N-1:0][AW-1:0]   wbm_adr;
    logic [N-1:0][DW-1:0]   wbm_dat_m;
    logic [N-1:0][SW-1:0]   wbm_sel;
    logic [N-1:0][DW-1:0]   wbm_dat_s;
    logic [N-1:0]           wbm_ack, wbm_err, wbm_stall;
    logic                   wbs_cyc, wbs_stb, wbs_we;
    logic [AW-1:0]          wbs_adr;
    logic [DW-1:0]          wbs_dat_m;
    logic [SW-1:0]          wbs_sel;
    logic [DW-1:0]          wbs_dat_s;
    logic                   wbs_ack, wbs_err, wbs_stall;
    logic [N-1:0]           grant_o;

    always #5 clk = ~clk;

    wb_arbiter_n #(
        .NUM_MASTERS    (N),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .SELECT_WIDTH   (SW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbm_cyc   (wbm_cyc),
        .wbm_stb   (wbm_stb),
        .wbm_we    (wbm_we),
        .wbm_adr   (wbm_adr),
        .wbm_dat_m (wbm_dat_m),
        .wbm_sel   (wbm_sel),
        .wbm_dat_s (wbm_dat_s),
        .wbm_ack   (wbm_ack),
        .wbm_err   (wbm_err),
        .wbm_stall (wbm_stall),
        .wbs_cyc   (wbs_cyc),
        .wbs_stb   (wbs_stb),
        .wbs_we    (wbs_we),
        .wbs_adr   (wbs_adr),
        .wbs_dat_m (wbs_dat_m),
        .wbs_sel   (wbs_sel),
        .wbs_dat_s (wbs_dat_s),
        .wbs_ack   (wbs_ack),
        .wbs_err   (wbs_err),
        .wbs_stall (wbs_stall),
        .grant_o   (grant_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the bus (-1 = nobody), the round-robin
    // pointer, the watchdog count and whether the owner is being aborted.
    // ------------------------------------------------------------------
    int m_g     = -1;
    int m_last  = N - 1;
    int m_cnt   = 0;
    bit m_abort = 1'b0;

    always @(negedge clk) begin : model_cmp
        logic [N-1:0] e_ack, e_err, e_stall;
        logic         routed, fwd, hit;
        if (!rst_n) begin
            m_g     = -1;
            m_last  = N - 1;
            m_cnt   = 0;
            m_abort = 1'b0;
        end
        routed = (m_g >= 0) && !m_abort;
        fwd    = routed ? wbm_cyc[m_g] : 1'b0;
        hit    = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        hit    = fwd && !wbs_ack && !wbs_err && (m_cnt == TMO - 1);
`endif
        e_ack   = '0;
        e_err   = '0;
        e_stall = '1;
        if (routed) begin
            if (hit) begin
                e_err[m_g] = 1'b1;
            end else begin
                e_ack[m_g]   = wbs_ack;
                e_err[m_g]   = wbs_err;
                e_stall[m_g] = wbs_stall;
            end
        end
        chk("wbs_cyc",   wbs_cyc,   fwd && !hit);
        chk("wbs_stb",   wbs_stb,   (fwd && !hit) ? wbm_stb[m_g] : 1'b0);
        chk("wbs_we",    wbs_we,    routed ? wbm_we[m_g] : 1'b0);
        chk("wbs_adr",   wbs_adr,   routed ? wbm_adr[m_g] : '0);
        chk("wbs_dat_m", wbs_dat_m, routed ? wbm_dat_m[m_g] : '0);
        chk("wbs_sel",   wbs_sel,   routed ? wbm_sel[m_g] : '0);
        chk("wbm_ack",   wbm_ack,   e_ack);
        chk("wbm_err",   wbm_err,   e_err);
        chk("wbm_stall", wbm_stall, e_stall);
        chk("grant_o",   grant_o,   (m_g >= 0) ? (64'd1 << m_g) : 64'd0);
        for (int i = 0; i < N; i++)
            chk("wbm_dat_s", wbm_dat_s[i], wbs_dat_s);

        if (rst_n) begin
            if (m_g < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (wbm_cyc[c]) begin
                        m_g    = c;
                        m_last = c;
                        m_cnt  = 0;
                        break;
                    end
                end
            end else if (m_abort) begin
                if (!wbm_cyc[m_g]) begin
                    m_g     = -1;
                    m_abort = 1'b0;
                end
            end else if (!wbm_cyc[m_g]) begin
                m_g   = -1;
                m_cnt = 0;
            end else if (hit) begin
                m_abort = 1'b1;
                m_cnt   = 0;
            end else if (wbs_ack || wbs_err) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event monitor: response counts per master and the grant history.
    // ------------------------------------------------------------------
    int           ack_cnt[N];
    int           err_cnt[N];
    int           grant_log[$];
    int           cyc_no = 0;
    int           direct_switch = 0;
    int           last_grant_cyc = 0;
    int           last_err_cyc = 0;
    logic [N-1:0] prev_g = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            ack_cnt[i] = 0;
            err_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc_no++;
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    ack_cnt[i] += int'(wbm_ack[i]);
                    err_cnt[i] += int'(wbm_err[i]);
                end
            end
            if (grant_o != prev_g && grant_o != '0) begin
                for (int i = 0; i < N; i++)
                    if (grant_o[i]) grant_log.push_back(i);
                if (prev_g != '0) direct_switch++;
                last_grant_cyc = cyc_no;
            end
            if (|wbm_err) last_err_cyc = cyc_no;
            prev_g = grant_o;
        end
    end

    // ------------------------------------------------------------------
    // Slave responder.
    // ------------------------------------------------------------------
    int s_mode = S_AUTO;
    int s_beats = 0;
    int s_stall_left = 0;

    initial begin
        logic acc;
        wbs_ack   = 1'b0;
        wbs_err   = 1'b0;
        wbs_stall = 1'b0;
        wbs_dat_s = '0;
        forever begin
            @(negedge clk);
            acc = wbs_cyc && wbs_stb && !wbs_stall;
            if (acc) s_beats++;
            if (acc && s_beats == 1 && s_mode == S_BURST) s_stall_left = 2;
            @(posedge clk);
            #1;
            wbs_ack   = 1'b0;
            wbs_err   = 1'b0;
            wbs_stall = 1'b0;
            case (s_mode)
                S_AUTO:  wbs_ack = acc;
                S_BURST: begin
                    wbs_ack   = acc;
                    wbs_stall = (s_stall_left > 0);
                    if (s_stall_left > 0) s_stall_left--;
                end
                S_ERR1: begin
                    wbs_err = acc && (s_beats == 1);
                    wbs_ack = acc && (s_beats != 1);
                end
                S_RAND: begin
                    wbs_ack   = ($urandom_range(2) == 0);
                    wbs_err   = ($urandom_range(19) == 0);
                    wbs_stall = ($urandom_range(2) == 0);
                end
                default: ;
            endcase
            wbs_dat_s = $urandom;
        end
    end

    // One master transaction: issue 'beats' strobes, wait for as many
    // ack/err responses, keep cyc for 'hold' extra cycles, then release.
    task automatic mxfer(input int m, input int beats, input int hold);
        int   sent, done, t;
        logic acc;
        sent = 0;
        done = 0;
        t    = 0;
        wbm_cyc[m]   = 1'b1;
        wbm_stb[m]   = 1'b1;
        wbm_we[m]    = 1'($urandom_range(1));
        wbm_adr[m]   = $urandom;
        wbm_dat_m[m] = $urandom;
        wbm_sel[m]   = '1;
        while (done < beats && t < 200) begin
            @(negedge clk);
            acc = wbm_stb[m] && !wbm_stall[m];
            if (acc) sent++;
            if (wbm_ack[m] || wbm_err[m]) done++;
            @(posedge clk);
            #1;
            t++;
            if (sent >= beats) begin
                wbm_stb[m] = 1'b0;
            end else if (acc) begin
                wbm_adr[m]   = $urandom;
                wbm_dat_m[m] = $urandom;
            end
        end
        chk($sformatf("xfer_m%0d_responses", m), done, beats);
        repeat (hold) step(1);
        wbm_cyc[m] = 1'b0;
        wbm_stb[m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, g0, d0, e0, eo;
        int exp_order[3];
        wbm_cyc   = '0;
        wbm_stb   = '0;
        wbm_we    = '0;
        wbm_adr   = '0;
        wbm_dat_m = '0;
        wbm_sel   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_stall", wbm_stall, 4'hF);
        chk("rst_wbs_cyc", wbs_cyc, 0);
        rst_n = 1'b1;
        step(1);

        // Single master write on master 2
        a0 = ack_cnt[2];
        wbm_cyc[2]   = 1'b1;
        wbm_stb[2]   = 1'b1;
        wbm_we[2]    = 1'b1;
        wbm_adr[2]   = 32'h1000_0000;
        wbm_dat_m[2] = 32'hCAFE_F00D;
        wbm_sel[2]   = 4'hF;
        step(1);
        chk("t1_grant", grant_o, 4'b0100);
        chk("t1_adr", wbs_adr, 32'h1000_0000);
        chk("t1_other_stall", wbm_stall & 4'b1011, 4'b1011);
        step(1);
        wbm_stb[2] = 1'b0;
        step(1);
        wbm_cyc[2] = 1'b0;
        step(2);
        chk("t1_acks", ack_cnt[2] - a0, 1);
        chk("t1_idle", grant_o, 0);

        // Contention from a fresh reset: order 0, 1, 3 with a gap between
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        g0 = grant_log.size();
        d0 = direct_switch;
        fork
            mxfer(0, 1, 0);
            mxfer(1, 1, 0);
            mxfer(3, 1, 0);
        join
        step(2);
        exp_order = '{0, 1, 3};
        chk("t2_grants", grant_log.size() - g0, 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t2_order%0d", k),
                (g0 + k < grant_log.size()) ? grant_log[g0 + k] : -1, exp_order[k]);
        chk("t2_no_direct_switch", direct_switch - d0, 0);

        // Pipelined burst on master 1 with a stalled second beat; master 0 waits
        s_mode  = S_BURST;
        s_beats = 0;
        a0 = ack_cnt[1];
        g0 = grant_log.size();
        fork
            mxfer(1, 4, 0);
            begin
                step(2);
                chk("t3_m0_held", wbm_stall[0], 1);
                mxfer(0, 1, 0);
            end
        join
        step(2);
        chk("t3_acks_m1", ack_cnt[1] - a0, 4);
        chk("t3_grants", grant_log.size() - g0, 2);
        chk("t3_first", (g0 < grant_log.size()) ? grant_log[g0] : -1, 1);
        chk("t3_second", (g0 + 1 < grant_log.size()) ? grant_log[g0 + 1] : -1, 0);

        // Reset in the middle of master 0's cycle
        s_mode = S_NOACK;
        wbm_cyc[0] = 1'b1;
        wbm_stb[0] = 1'b1;
        wbm_adr[0] = $urandom;
        step(3);
        chk("t4_pre_cyc", wbs_cyc, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_async_cyc", wbs_cyc, 0);
        chk("t4_async_grant", grant_o, 0);
        @(posedge clk);
        #1;
        wbm_cyc[3] = 1'b1;
        wbm_stb[3] = 1'b1;
        rst_n = 1'b1;
        step(1);
        chk("t4_first_after_reset", grant_o, 4'b0001);
        wbm_cyc = '0;
        wbm_stb = '0;
        step(3);

`ifdef WB_ARB_TIMEOUT_EN
        // Hung slave: err on cycle 16 of the grant, then abort until release
        s_mode = S_NOACK;
        e0 = err_cnt[2];
        mxfer(2, 1, 0);
        step(3);
        chk("t5_err_count", err_cnt[2] - e0, 1);
        chk("t5_err_cycle", last_err_cyc - last_grant_cyc, TMO - 1);
        chk("t5_idle", grant_o, 0);
`endif

        // Slave error on the first beat reaches master 3 only
        s_mode  = S_ERR1;
        s_beats = 0;
        e0 = err_cnt[3];
        eo = err_cnt[0] + err_cnt[1] + err_cnt[2];
        mxfer(3, 1, 3);
        step(2);
        chk("t6_err_m3", err_cnt[3] - e0, 1);
        chk("t6_err_others", err_cnt[0] + err_cnt[1] + err_cnt[2] - eo, 0);

        // Randomised traffic against the model
        s_mode = S_RAND;
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (!wbm_cyc[i]) begin
                    if ($urandom_range(3) == 0) begin
                        wbm_cyc[i] = 1'b1;
                        wbm_stb[i] = 1'($urandom_range(1));
                    end
                end else if ($urandom_range(7) == 0) begin
                    wbm_cyc[i] = 1'b0;
                    wbm_stb[i] = 1'b0;
                end else begin
                    wbm_stb[i] = 1'($urandom_range(1));
                end
                wbm_we[i]    = 1'($urandom_range(1));
                wbm_adr[i]   = $urandom;
                wbm_dat_m[i] = $urandom;
                wbm_sel[i]   = 4'($urandom_range(15));
            end
            step(1);
        end
        wbm_cyc = '0;
        wbm_stb = '0;
        step(4);
        chk("end_idle", grant_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_arbiter_n
